imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into
// 32-bit words and writes them to consecutive word addresses while holding
// the CPU in reset. Optional trailing checksum byte when
// IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned MAX_WORDS = 64,
  parameter int unsigned AW        = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [15:0]   num_words,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          cpu_hold
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE,
    ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   num_q, num_d;
  logic [1:0]    idx_q, idx_d;
  logic [23:0]   word_q, word_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif
  logic          ready_q, we_q, busy_q, done_q, error_q, hold_q;
  logic          accept;
  logic          len_ok;
  logic          rx_state_d;

  assign accept = byte_valid && ready_q;
  assign len_ok = (num_words != '0) && (32'(num_words) <= MAX_WORDS);

  // Next-state, byte assembly and address/counter bookkeeping.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    idx_d   = idx_q;
    word_d  = word_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          if (len_ok) begin
            state_d = RECV;
            addr_d  = '0;
            cnt_d   = '0;
            idx_d   = '0;
            num_d   = num_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else begin
            state_d = ERR;
          end
        end
      end
      RECV: begin
        if (accept) begin
          idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d = sum_q + byte_in;
`endif
          case (idx_q)
            2'd0: word_d[7:0]   = byte_in;
            2'd1: word_d[15:8]  = byte_in;
            2'd2: word_d[23:16] = byte_in;
            default: begin
              // The fourth byte goes straight to the write register.
              state_d = WRITE;
              waddr_d = addr_q;
              wdata_d = {byte_in, word_q};
            end
          endcase
        end
      end
      WRITE: begin
        addr_d = addr_q + AW'(4);
        cnt_d  = cnt_q + 16'd1;
        if (cnt_d == num_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) state_d = (byte_in == sum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign rx_state_d = (state_d == RECV) || (state_d == CHECK);
`else
  assign rx_state_d = (state_d == RECV);
`endif

  // State, datapath and outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
      ready_q <= rx_state_d;
      we_q    <= (state_d == WRITE);
      busy_q  <= rx_state_d || (state_d == WRITE);
      done_q  <= (state_d == DONE);
      error_q <= (state_d == ERR);
      hold_q  <= (state_d != DONE);
    end
  end

  assign byte_ready = ready_q;
  assign mem_we     = we_q;
  assign mem_addr   = waddr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_hold   = hold_q;

endmodule
